// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED among four requesters: each granted requester gets
// N on/off blink periods at a latched rate, then a dark gap, then a one-cycle done pulse.
module led_blink_sched #(
  parameter int unsigned DIV_W     = 27,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         rate,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] req_count,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy,
  output logic               led
);

  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       done_q, done_d;
  logic             led_q, led_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       rate_q, rate_d;
  logic [1:0]       idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic [3:0]       elig;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [CNT_W-1:0] win_cnt;
  logic [DIV_W-1:0] mask;
  logic             tick;

  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = req[i] && (req_count[i*CNT_W +: CNT_W] != '0);
    end
  end

  // Scan offsets from farthest to nearest so the first eligible index at or after rr_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    cand    = '0;
    for (int o = 3; o >= 0; o--) begin
      cand = rr_q + 2'(o);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_cnt = req_count[CNT_W*win_idx +: CNT_W];

  // Half-period exponent k = DIV_W-1-rate, so the mask holds k ones.
  assign mask = {DIV_W{1'b1}} >> ({1'b0, rate_q} + 3'd1);
  assign tick = ((presc_q & mask) == mask);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    led_d   = led_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    rr_d    = rr_q;
    rate_d  = rate_q;
    idx_d   = idx_q;
    gap_d   = gap_q;

    if (state_q != StIdle) begin
      presc_d = presc_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StOn;
          gnt_d   = 4'b0001 << win_idx;
          led_d   = 1'b1;
          presc_d = '0;
          rem_d   = win_cnt;
          rate_d  = rate;
          idx_d   = win_idx;
        end
      end
      StOn: begin
        if (tick) begin
          led_d   = 1'b0;
          state_d = StOff;
        end
      end
      StOff: begin
        if (tick) begin
          if (rem_q > CNT_W'(1)) begin
            rem_d   = rem_q - 1'b1;
            led_d   = 1'b1;
            state_d = StOn;
          end else begin
            rem_d   = '0;
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        led_d = 1'b0;
        if (tick) begin
          if (gap_q == GapW'(GAP_TICKS - 1)) begin
            done_d  = 4'b0001 << idx_q;
            gnt_d   = '0;
            rr_d    = idx_q + 2'd1;
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
      presc_q <= '0;
      rem_q   <= '0;
      rr_q    <= '0;
      rate_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      rr_q    <= rr_d;
      rate_q  <= rate_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);
  assign led  = led_q;

endmodule
